// File: rtl/multi_edge_detect_pkg.sv
// multi_edge_detect_pkg: shared constants for the multi-channel edge detector.
//   MODE_*  : per-channel 2-bit mode encoding (bit0 = rising, bit1 = falling)
//   sat_max : all-ones value for a counter of the given width (saturation limit)
package multi_edge_detect_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  function automatic logic [31:0] sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// edge_chan: one channel of multi_edge_detect.
//   din          : asynchronous input level
//   mode[1:0]    : off / rise / fall / both qualification of evt
//   clr          : synchronous clear of sticky and cnt
//   rise, fall   : registered one-cycle edge pulses (mode-independent)
//   evt          : registered one-cycle pulse for a mode-qualified edge
//   sticky, cnt  : event history, updated from the registered evt
// Optional macro MULTI_EDGE_DETECT_DEBOUNCE_EN inserts a DB_CYCLES
// stability filter between the synchroniser and the edge logic.
module edge_chan
  import multi_edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int DB_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             rise,
  output logic             fall,
  output logic             evt,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  if (SYNC_STAGES < 2 || CNT_W < 1 || DB_CYCLES < 1) begin : g_param_chk
    $error("edge_chan: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic s, lvl, lvl_d, re, fe, rise_en, fall_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], din};
  end
  assign s = sync[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DETECT_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  logic [DB_W-1:0] db_cnt;

  // lvl follows s only once s has disagreed with it for DB_CYCLES
  // consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl    <= 1'b0;
      db_cnt <= '0;
    end else if (s == lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      lvl    <= s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  assign lvl = s;
`endif

  assign re = lvl & ~lvl_d;
  assign fe = ~lvl & lvl_d;

  always_comb begin
    rise_en = 1'b0;
    fall_en = 1'b0;
    case (mode)
      MODE_OFF:  begin rise_en = 1'b0; fall_en = 1'b0; end
      MODE_RISE: begin rise_en = 1'b1; fall_en = 1'b0; end
      MODE_FALL: begin rise_en = 1'b0; fall_en = 1'b1; end
      MODE_BOTH: begin rise_en = 1'b1; fall_en = 1'b1; end
      default:   begin rise_en = 1'b0; fall_en = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      evt    <= 1'b0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else begin
      lvl_d  <= lvl;
      rise   <= re;
      fall   <= fe;
      evt    <= (rise_en & re) | (fall_en & fe);
      // A simultaneous event beats the clear, so no event is lost.
      sticky <= evt | (sticky & ~clr);
      if (clr)                        cnt <= evt ? CNT_W'(1) : '0;
      else if (evt && cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multi_edge_detect.sv
// multi_edge_detect: N independent synchronised edge detectors with
// per-channel mode qualification, sticky flags and saturating counters.
//   din[N]            : asynchronous inputs
//   mode[2N]          : channel i at mode[2i+1:2i]
//   clr[N]            : per-channel clear of sticky/cnt
//   rise/fall/evt[N]  : registered one-cycle pulses
//   sticky[N]         : latched event flags
//   cnt[N*CNT_W]      : channel i at cnt[(i+1)*CNT_W-1 : i*CNT_W]
// Optional macro MULTI_EDGE_DETECT_DEBOUNCE_EN enables per-channel debounce.
module multi_edge_detect
  import multi_edge_detect_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int DB_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       din,
  input  logic [2*N-1:0]     mode,
  input  logic [N-1:0]       clr,
  output logic [N-1:0]       rise,
  output logic [N-1:0]       fall,
  output logic [N-1:0]       evt,
  output logic [N-1:0]       sticky,
  output logic [N*CNT_W-1:0] cnt
);

  if (N < 1) begin : g_param_chk
    $error("multi_edge_detect: N must be >= 1");
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .DB_CYCLES   (DB_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (din[i]),
      .mode   (mode[2*i +: 2]),
      .clr    (clr[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .evt    (evt[i]),
      .sticky (sticky[i]),
      .cnt    (cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Scoreboard bench for multi_edge_detect (N=4, SYNC_STAGES=2, CNT_W=4, DB_CYCLES=4).
// Stimulus pushes expected pulses and history snapshots tagged with the cycle
// they must appear in; a monitor on the falling edge pops and compares.
module tb_multi_edge_detect;
  import multi_edge_detect_pkg::*;

  localparam int N = 4, SS = 2, CW = 4, DB = 4;
`ifdef MULTI_EDGE_DETECT_DEBOUNCE_EN
  localparam int DBL = DB;
`else
  localparam int DBL = 0;
`endif
  localparam int LAT  = SS + 1 + DBL;
  localparam int HOLD = 4 + 2 * DBL;

  typedef struct { int at; logic [N-1:0] r, f, e; } pulse_t;
  typedef struct { int at; int ch; logic st; logic [CW-1:0] c; } state_t;

  logic            clk = 1'b0, rst_n;
  logic [N-1:0]    din, clr, rise, fall, evt, sticky;
  logic [2*N-1:0]  mode;
  logic [N*CW-1:0] cnt;

  pulse_t pq[$];
  state_t sq[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;

  multi_edge_detect #(.N(N), .SYNC_STAGES(SS), .CNT_W(CW), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .clr(clr),
    .rise(rise), .fall(fall), .evt(evt), .sticky(sticky), .cnt(cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_pulse(input int at, input logic [N-1:0] r, f, e);
    pulse_t p;
    p.at = at; p.r = r; p.f = f; p.e = e;
    pq.push_back(p);
  endtask

  task automatic push_state(input int at, input int ch, input logic st, input logic [CW-1:0] c);
    state_t s;
    s.at = at; s.ch = ch; s.st = st; s.c = c;
    sq.push_back(s);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: history snapshots are due at a given cycle; any pulse on
  // rise/fall/evt must match the head of the pulse queue in cycle and value.
  always @(negedge clk) begin
    pulse_t p;
    state_t s;
    if (rst_n) begin
      while (sq.size() > 0 && sq[0].at <= cyc) begin
        s = sq.pop_front();
        n_cmp++;
        if (s.at != cyc || sticky[s.ch] !== s.st || cnt[s.ch*CW +: CW] !== s.c) begin
          n_bad++;
          $display("FAIL state ch%0d @%0d: got sticky=%b cnt=%0d at %0d, want sticky=%b cnt=%0d",
                   s.ch, s.at, sticky[s.ch], cnt[s.ch*CW +: CW], cyc, s.st, s.c);
        end
      end
      if ((rise | fall | evt) != '0) begin
        n_cmp++;
        if (pq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected pulse @%0d: rise=%b fall=%b evt=%b", cyc, rise, fall, evt);
        end else begin
          p = pq.pop_front();
          if (p.at != cyc || rise !== p.r || fall !== p.f || evt !== p.e) begin
            n_bad++;
            $display("FAIL pulse: got @%0d rise=%b fall=%b evt=%b, want @%0d rise=%b fall=%b evt=%b",
                     cyc, rise, fall, evt, p.at, p.r, p.f, p.e);
          end
        end
      end
    end
  end

  initial begin
    int t, k;
    rst_n = 1'b0; din = '0; mode = '0; clr = '0;
    step(3); #1;
    chk("reset rise", 32'(rise), 0);
    chk("reset fall", 32'(fall), 0);
    chk("reset evt", 32'(evt), 0);
    chk("reset sticky", 32'(sticky), 0);
    chk("reset cnt", 32'(cnt), 0);
    step(1);
    mode  = {MODE_BOTH, MODE_BOTH, MODE_FALL, MODE_RISE};
    rst_n = 1'b1;
    step(4);

    // ch0 rise mode: a single rising edge
    t = cyc; din[0] = 1'b1;
    push_pulse(t + LAT, 4'b0001, 4'b0000, 4'b0001);
    push_state(t + LAT, 0, 1'b0, 4'd0);
    push_state(t + LAT + 1, 0, 1'b1, 4'd1);
    step(HOLD + 4);

    // ch1 fall mode: 0->1 prep, then 1->0->1; only the fall counts
    t = cyc; din[1] = 1'b1;
    push_pulse(t + LAT, 4'b0010, 4'b0000, 4'b0000);
    push_state(t + LAT + 1, 1, 1'b0, 4'd0);
    step(HOLD + 6);
    t = cyc; din[1] = 1'b0;
    push_pulse(t + LAT, 4'b0000, 4'b0010, 4'b0010);
    push_state(t + LAT + 1, 1, 1'b1, 4'd1);
    step(HOLD + 6);
    t = cyc; din[1] = 1'b1;
    push_pulse(t + LAT, 4'b0010, 4'b0000, 4'b0000);
    push_state(t + LAT + 1, 1, 1'b1, 4'd1);
    step(HOLD + 6);

    // ch2 both mode: 20 pulses = 40 edges, counter saturates at 15
    for (int p = 0; p < 40; p++) begin
      t = cyc; din[2] = ~din[2];
      if (din[2]) push_pulse(t + LAT, 4'b0100, 4'b0000, 4'b0100);
      else        push_pulse(t + LAT, 4'b0000, 4'b0100, 4'b0100);
      push_state(t + LAT + 1, 2, 1'b1, CW'((p + 1 > 15) ? 15 : p + 1));
      step(HOLD);
    end
    step(LAT + 2);

    // ch3 both mode: five edges to cnt=5, then clr coincident with evt
    for (int p = 0; p < 5; p++) begin
      t = cyc; din[3] = ~din[3];
      if (din[3]) push_pulse(t + LAT, 4'b1000, 4'b0000, 4'b1000);
      else        push_pulse(t + LAT, 4'b0000, 4'b1000, 4'b1000);
      push_state(t + LAT + 1, 3, 1'b1, CW'(p + 1));
      step(HOLD);
    end
    step(LAT + 2);
    t = cyc; din[3] = 1'b0;
    push_pulse(t + LAT, 4'b0000, 4'b1000, 4'b1000);
    step(LAT);
    clr[3] = 1'b1;
    push_state(cyc + 1, 3, 1'b1, 4'd1);
    step(1);
    clr[3] = 1'b0;
    step(2);
    clr[3] = 1'b1;
    push_state(cyc + 1, 3, 1'b0, 4'd0);
    step(1);
    clr[3] = 1'b0;
    push_state(cyc + 2, 3, 1'b0, 4'd0);
    step(4);

    // ch0: four more rises to cnt=5; falls give no evt in rise mode
    k = 1;
    for (int p = 0; p < 8; p++) begin
      t = cyc; din[0] = ~din[0];
      if (din[0]) begin
        k++;
        push_pulse(t + LAT, 4'b0001, 4'b0000, 4'b0001);
        push_state(t + LAT + 1, 0, 1'b1, CW'(k));
      end else begin
        push_pulse(t + LAT, 4'b0000, 4'b0001, 4'b0000);
      end
      step(HOLD);
    end
    step(LAT + 2);

    // asynchronous reset mid-cycle, din[0] held high through release
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rise", 32'(rise), 0);
    chk("async rst fall", 32'(fall), 0);
    chk("async rst evt", 32'(evt), 0);
    chk("async rst sticky", 32'(sticky), 0);
    chk("async rst cnt", 32'(cnt), 0);
    din[1] = 1'b0;
    step(3);
    rst_n = 1'b1;
    t = cyc;
    push_pulse(t + LAT, 4'b0001, 4'b0000, 4'b0001);
    push_state(t + LAT + 1, 0, 1'b1, 4'd1);
    step(LAT + 6);

`ifdef MULTI_EDGE_DETECT_DEBOUNCE_EN
    // 2-cycle glitch is filtered; 6-cycle pulse passes
    din[2] = 1'b1; step(2); din[2] = 1'b0;
    step(LAT + 6);
    t = cyc; din[2] = 1'b1;
    push_pulse(t + LAT, 4'b0100, 4'b0000, 4'b0100);
    step(6); din[2] = 1'b0;
    push_pulse(t + 6 + LAT, 4'b0000, 4'b0100, 4'b0100);
    push_state(t + 6 + LAT + 1, 2, 1'b1, 4'd2);
    step(LAT + 8);
`endif

    #1;
    chk("pulse queue drained", pq.size(), 0);
    chk("state queue drained", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
